// File: rtl/mult4_acc_if.sv
// Bus between the 4x4 multiplier side and the product accumulator.
// The master drives products and commands; the slave (mult4_acc) returns the sum.
interface mult4_acc_if;
    logic [7:0]  pp;
    logic        done;
    logic        start;
    logic [3:0]  len;
    logic [11:0] acc;
    logic [4:0]  count;
    logic        busy;
    logic        valid;
    logic [7:0]  peak;

    modport master (
        output pp, done, start, len,
        input  acc, count, busy, valid, peak
    );

    modport slave (
        input  pp, done, start, len,
        output acc, count, busy, valid, peak
    );
endinterface

// File: rtl/mult4_acc.sv
// mult4_acc: sums a programmed number (1..16) of 8-bit products from the
// multiplier into a 12-bit accumulator, one product per rising edge of done.
// Optional feature macro: MULT4_ACC_PEAK_EN adds a running-maximum register
// on the peak output; without it peak is a constant 0.
module mult4_acc (
    input  logic        clk,
    input  logic        rst,
    mult4_acc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t      state;
    logic [11:0] acc_r;
    logic [4:0]  count_r;
    logic [4:0]  remaining;
    logic        done_q;
    logic        busy_r;
    logic        valid_r;
    logic        accept;

    // A held-high done must count only once, so only its rising edge is used.
    assign accept = bus.done & ~done_q;

    // Main control: start always wins; products are taken only while in ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc_r     <= 12'h000;
            count_r   <= 5'd0;
            remaining <= 5'd0;
            done_q    <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            done_q <= bus.done;
            if (bus.start) begin
                state     <= ACC;
                acc_r     <= 12'h000;
                count_r   <= 5'd0;
                remaining <= (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
                busy_r    <= 1'b1;
                valid_r   <= 1'b0;
            end else if (state == ACC && accept) begin
                // 16 * 225 = 3600 fits in 12 bits, so no overflow handling.
                acc_r     <= acc_r + {4'h0, bus.pp};
                count_r   <= count_r + 5'd1;
                remaining <= remaining - 5'd1;
                if (remaining == 5'd1) begin
                    state   <= HOLD;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.acc   = acc_r;
    assign bus.count = count_r;
    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;

`ifdef MULT4_ACC_PEAK_EN
    logic [7:0] peak_r;

    // Largest product of the current sum; frozen outside ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_r <= 8'h00;
        end else if (bus.start) begin
            peak_r <= 8'h00;
        end else if (state == ACC && accept && bus.pp > peak_r) begin
            peak_r <= bus.pp;
        end
    end

    assign bus.peak = peak_r;
`else
    assign bus.peak = 8'h00;
`endif
endmodule

// File: tb/tb_mult4_acc.sv
// Self-checking bench for mult4_acc: directed test-plan steps followed by
// random traffic, compared against a queue-based model of the current sum.
module tb_mult4_acc;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    mult4_acc_if bus ();

    mult4_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the products accepted into the current sum, the
    // requested length and the phase (0 idle, 1 collecting, 2 holding).
    logic [7:0] prods[$];
    int         target;
    int         phase;
    logic       prev_done;

    function automatic int q_sum();
        int s = 0;
        foreach (prods[i]) s += prods[i];
        return s;
    endfunction

    function automatic int q_max();
        int m = 0;
        foreach (prods[i]) if (prods[i] > m) m = prods[i];
        return m;
    endfunction

    task automatic model_reset();
        prods.delete();
        target    = 0;
        phase     = 0;
        prev_done = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic [3:0] ln,
                              input logic dn, input logic [7:0] p);
        logic rise;
        rise      = dn && !prev_done;
        prev_done = dn;
        if (st) begin
            prods.delete();
            target = (ln == 0) ? 16 : int'(ln);
            phase  = 1;
        end else if (phase == 1 && rise) begin
            prods.push_back(p);
            if (prods.size() == target) phase = 2;
        end
    endtask

    task automatic check(input string name, input logic [11:0] obs,
                         input logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int pk;
`ifdef MULT4_ACC_PEAK_EN
        pk = q_max();
`else
        pk = 0;
`endif
        check({tag, ".acc"},   bus.acc,           12'(q_sum()));
        check({tag, ".count"}, {7'h0, bus.count}, 12'(prods.size()));
        check({tag, ".busy"},  {11'h0, bus.busy},  12'(phase == 1));
        check({tag, ".valid"}, {11'h0, bus.valid}, 12'(phase == 2));
        check({tag, ".peak"},  {4'h0, bus.peak},   12'(pk));
    endtask

    // One clock: drive at the falling edge, model the rising edge, check after it.
    task automatic step(input string tag, input logic st, input logic [3:0] ln,
                        input logic dn, input logic [7:0] p);
        @(negedge clk);
        bus.start = st;
        bus.len   = ln;
        bus.done  = dn;
        bus.pp    = p;
        @(posedge clk);
        model_edge(st, ln, dn, p);
        #1;
        check_all(tag);
    endtask

    // A done pulse: one cycle high, one cycle low.
    task automatic pulse(input string tag, input logic [7:0] p);
        step(tag, 1'b0, 4'd0, 1'b1, p);
        step(tag, 1'b0, 4'd0, 1'b0, 8'h00);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, ".acc"},   bus.acc,           12'h000);
        check({tag, ".count"}, {7'h0, bus.count}, 12'h000);
        check({tag, ".busy"},  {11'h0, bus.busy},  12'h000);
        check({tag, ".valid"}, {11'h0, bus.valid}, 12'h000);
        check({tag, ".peak"},  {4'h0, bus.peak},   12'h000);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.len   = 4'd0;
        bus.done  = 1'b0;
        bus.pp    = 8'h00;
        model_reset();
        #3;
        outputs_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Basic sum: 15 + 63 + 225 = 0x12F
        step("basic", 1'b1, 4'd3, 1'b0, 8'h00);
        pulse("basic", 8'd15);
        pulse("basic", 8'd63);
        step("basic", 1'b0, 4'd0, 1'b1, 8'd225);
        check("basic.acc_const", bus.acc, 12'h12F);
        check("basic.valid_const", {11'h0, bus.valid}, 12'h001);
        step("basic", 1'b0, 4'd0, 1'b0, 8'h00);

        // Max length: sixteen 225s = 3600, a 17th pulse changes nothing
        step("max", 1'b1, 4'd0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) pulse("max", 8'd225);
        check("max.acc_const", bus.acc, 12'hE10);
        check("max.count_const", {7'h0, bus.count}, 12'd16);
        pulse("max17", 8'd225);
        check("max17.acc_const", bus.acc, 12'hE10);

        // Held done counts once
        step("held", 1'b1, 4'd2, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step("held", 1'b0, 4'd0, 1'b1, 8'h40);
        step("held", 1'b0, 4'd0, 1'b0, 8'h00);
        pulse("held", 8'h10);
        check("held.acc_const", bus.acc, 12'h050);
        check("held.count_const", {7'h0, bus.count}, 12'd2);

        // Abort mid-sum; coincident done rise is discarded
        step("abort", 1'b1, 4'd4, 1'b0, 8'h00);
        pulse("abort", 8'd100);
        step("abort", 1'b1, 4'd1, 1'b1, 8'd50);
        check("abort.acc_const", bus.acc, 12'h000);
        check("abort.count_const", {7'h0, bus.count}, 12'd0);
        step("abort", 1'b0, 4'd0, 1'b0, 8'h00);
        step("abort", 1'b0, 4'd0, 1'b1, 8'd9);
        check("abort.acc9", bus.acc, 12'd9);
        check("abort.valid", {11'h0, bus.valid}, 12'h001);

        // Restart from HOLD; done rise right after start is counted
        step("restart", 1'b1, 4'd1, 1'b0, 8'h00);
        check("restart.valid", {11'h0, bus.valid}, 12'h000);
        check("restart.busy", {11'h0, bus.busy}, 12'h001);
        step("restart", 1'b0, 4'd0, 1'b1, 8'd7);
        check("restart.acc7", bus.acc, 12'd7);
        step("restart", 1'b0, 4'd0, 1'b0, 8'h00);

        // Asynchronous reset mid-ACC with acc = 0x064
        step("rst", 1'b1, 4'd3, 1'b0, 8'h00);
        pulse("rst", 8'd100);
        check("rst.pre_acc", bus.acc, 12'h064);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        outputs_zero("rst_async");
        @(negedge clk);
        rst = 1'b1;
        pulse("rst_idle", 8'd33);
        pulse("rst_idle", 8'd44);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic       st;
            logic [3:0] ln;
            logic       dn;
            logic [7:0] p;
            st = ($urandom_range(0, 19) == 0);
            ln = 4'($urandom_range(0, 15));
            dn = 1'($urandom_range(0, 1));
            p  = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            step("rand", st, ln, dn, p);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
